// File: rtl/ahbl_splitter_n.sv
// ahbl_splitter_n: AHB-Lite address decoder and data-phase response mux for
// one master and NS slaves. Regions are base/mask pairs; the lowest index
// wins on overlap. An internal default slave answers unmapped active
// transfers with a two-cycle ERROR.
// Optional: define SPLITTER_TIMEOUT_EN to add a watchdog that aborts a slave
// stalling for TIMEOUT_CYCLES cycles and answers the master with ERROR.

// Per-slave region compare.
module ahbl_splitter_n_cmp (
  input  logic [31:0] addr,
  input  logic [31:0] base,
  input  logic [31:0] mask,
  output logic        hit
);
  assign hit = ((addr & mask) == (base & mask));
endmodule

module ahbl_splitter_n #(
  parameter int              NS             = 4,
  parameter logic [NS*32-1:0] S_BASE        = {32'h8000_0000, 32'h0000_0000,
                                               32'h2000_0000, 32'h4000_0000},
  parameter logic [NS*32-1:0] S_MASK        = {NS{32'hF000_0000}},
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  output logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic [NS-1:0]     S_HSEL,
  input  logic [NS*32-1:0]  S_HRDATA,
  input  logic [NS-1:0]     S_HREADYOUT,
  input  logic [NS-1:0]     S_HRESP,
  output logic              TIMEOUT
);

  localparam logic [31:0] DEAD   = 32'hBADD_BEEF;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic [NS-1:0]   sel_d;
  logic [NS-1:0]   hit_raw;
  logic [NS-1:0]   hit;
  logic            found;
  logic            hready;
  logic            hresp;
  logic [31:0]     hrdata;

  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY; neither matters here.
  logic unused_bits;
  assign unused_bits = ^{HTRANS[0], TO_LIM};

  // One comparator per slave region.
  for (genvar g = 0; g < NS; g++) begin : g_cmp
    ahbl_splitter_n_cmp u_cmp (
      .addr (HADDR),
      .base (S_BASE[g*32 +: 32]),
      .mask (S_MASK[g*32 +: 32]),
      .hit  (hit_raw[g])
    );
  end

  // Priority-reduce raw hits to one-hot, lowest index first.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (hit_raw[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign S_HSEL = hit;

  // Data-phase response mux, selected by the registered owner and state.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = DEAD;
    case (state)
      ST_SLV: begin
        hready = |(sel_d & S_HREADYOUT);
        hresp  = |(sel_d & S_HRESP);
        hrdata = '0;
        for (int i = 0; i < NS; i++)
          if (sel_d[i]) hrdata = S_HRDATA[i*32 +: 32];
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  assign HREADY = hready;
  assign HRESP  = hresp;
  assign HRDATA = hrdata;

`ifdef SPLITTER_TIMEOUT_EN
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        timeout_q;

  assign cnt_nxt = cnt + 16'd1;
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  // Owner/state FSM; advances on completed transfers, ERR1 always moves on.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
      sel_d <= '0;
`ifdef SPLITTER_TIMEOUT_EN
      cnt       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      if (state == ST_ERR1) begin
        state <= ST_ERR2;
        sel_d <= '0;
      end else if (hready) begin
        if (HTRANS[1] && found) begin
          state <= ST_SLV;
          sel_d <= hit;
        end else if (HTRANS[1]) begin
          state <= ST_ERR1;
          sel_d <= '0;
        end else begin
          state <= ST_IDLE;
          sel_d <= '0;
        end
      end
`ifdef SPLITTER_TIMEOUT_EN
      // Only a stalled SLV phase reaches here; abort it at the limit.
      else if (cnt_nxt == TO_LIM) begin
        state <= ST_ERR1;
        sel_d <= '0;
      end

      // Stall counter: runs only while the owning slave holds HREADYOUT low.
      timeout_q <= 1'b0;
      if (state == ST_SLV && !hready) begin
        if (cnt_nxt == TO_LIM) begin
          cnt       <= '0;
          timeout_q <= 1'b1;
        end else begin
          cnt <= cnt_nxt;
        end
      end else begin
        cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb_ahbl_splitter_n: directed and randomized checks of ahbl_splitter_n
// against a transaction-level reference model of the splitter rules.
module tb_ahbl_splitter_n;

`ifdef SPLITTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_N = 8;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic [31:0]  HADDR = '0;
  logic [1:0]   HTRANS = '0;
  logic         HREADY;
  logic [31:0]  HRDATA;
  logic         HRESP;
  logic [3:0]   S_HSEL;
  logic [127:0] S_HRDATA = '0;
  logic [3:0]   S_HREADYOUT = '1;
  logic [3:0]   S_HRESP = '0;
  logic         TIMEOUT;

  ahbl_splitter_n #(.TIMEOUT_CYCLES(TO_N)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .TIMEOUT(TIMEOUT)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Region map as the master sees it: slave index -> base, all 256 MB.
  logic [31:0] base_a [4];
  logic [31:0] sdat   [4];

  // Reference model: who owns the data phase and how far into an error.
  int own      = -1;  // owning slave, -1 for none
  int err_left = 0;   // 2 = first error cycle, 1 = second, 0 = none
  int stall    = 0;   // consecutive stalled cycles of the owner
  bit exp_to   = 1'b0;
  int to_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a[31:28] == base_a[i][31:28]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int d);
    logic [3:0] v;
    v = '0;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready();
    if (err_left == 2) return 1'b0;
    if (err_left == 1) return 1'b1;
    if (own >= 0) return S_HREADYOUT[own];
    return 1'b1;
  endfunction

  function automatic logic exp_resp();
    if (err_left != 0) return 1'b1;
    if (own >= 0) return S_HRESP[own];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data();
    if (own >= 0 && err_left == 0) return sdat[own];
    return 32'hBADD_BEEF;
  endfunction

  // One bus cycle: apply inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic [31:0] a, input logic [1:0] t,
                      input logic [3:0] rdy, input logic [3:0] rsp);
    logic rdy_e;
    int   d;
    HADDR = a; HTRANS = t; S_HREADYOUT = rdy; S_HRESP = rsp;
    for (int i = 0; i < 4; i++) begin
      sdat[i] = $urandom;
      S_HRDATA[i*32 +: 32] = sdat[i];
    end
    #2;
    rdy_e = exp_ready();
    chk("hsel",    {28'd0, S_HSEL}, {28'd0, onehot(dec(a))});
    chk("hready",  {31'd0, HREADY}, {31'd0, rdy_e});
    chk("hresp",   {31'd0, HRESP},  {31'd0, exp_resp()});
    chk("hrdata",  HRDATA, exp_data());
    chk("timeout", {31'd0, TIMEOUT}, {31'd0, exp_to});
    if (TIMEOUT) to_seen++;
    @(posedge HCLK);
    exp_to = 1'b0;
    if (err_left == 2) begin
      err_left = 1;
    end else if (rdy_e) begin
      stall = 0;
      d = dec(a);
      if (t[1] && d >= 0) begin own = d;  err_left = 0; end
      else if (t[1])      begin own = -1; err_left = 2; end
      else                begin own = -1; err_left = 0; end
    end else begin
      stall++;
      if (TO_EN && stall == TO_N) begin
        own = -1; err_left = 2; stall = 0; exp_to = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    base_a[0] = 32'h4000_0000; base_a[1] = 32'h2000_0000;
    base_a[2] = 32'h0000_0000; base_a[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) sdat[i] = '0;

    // Reset state
    #3;
    chk("rst_hready", {31'd0, HREADY}, 32'd1);
    chk("rst_hresp",  {31'd0, HRESP},  32'd0);
    chk("rst_hrdata", HRDATA, 32'hBADD_BEEF);
    chk("rst_timeout", {31'd0, TIMEOUT}, 32'd0);
    @(negedge HCLK); HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Read from slave0, then idle to see its data
    step(32'h4000_0010, 2'b10, 4'hF, 4'h0);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);
    // Unmapped NONSEQ: two-cycle default-slave error, then idle
    step(32'hF000_0000, 2'b10, 4'hF, 4'h0);
    step(32'hF000_0000, 2'b00, 4'hF, 4'h0);
    step(32'hF000_0000, 2'b00, 4'hF, 4'h0);
    step(32'hF000_0000, 2'b00, 4'hF, 4'h0);
    // IDLE to unmapped: no error
    step(32'hF000_0000, 2'b00, 4'hF, 4'h0);
    // Slave2 stalls 3 cycles while next NONSEQ to slave1 is pending
    step(32'h0000_0100, 2'b10, 4'hF, 4'h0);
    repeat (3) step(32'h2000_0000, 2'b10, 4'b1011, 4'h0);
    step(32'h2000_0000, 2'b10, 4'hF, 4'h0);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);
    // Slave's own two-cycle ERROR passes through
    step(32'h8000_0000, 2'b10, 4'hF, 4'h0);
    step(32'h0000_0000, 2'b00, 4'b0111, 4'b1000);
    step(32'h0000_0000, 2'b00, 4'hF, 4'b1000);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);

    // Async reset while slave2 stalls in its data phase
    step(32'h0000_0000, 2'b10, 4'hF, 4'h0);
    HTRANS = 2'b00; S_HREADYOUT = 4'b1011;
    #2;
    chk("pre_rst_hready", {31'd0, HREADY}, 32'd0);
    HRESET = 1'b1;
    #1;
    chk("arst_hready", {31'd0, HREADY}, 32'd1);
    chk("arst_hresp",  {31'd0, HRESP},  32'd0);
    chk("arst_hrdata", HRDATA, 32'hBADD_BEEF);
    own = -1; err_left = 0; stall = 0; exp_to = 1'b0;
    @(negedge HCLK); HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Slave3 stuck: watchdog fires with the macro, waits forever without
    to_seen = 0;
    step(32'h8000_0000, 2'b10, 4'hF, 4'h0);
    repeat (TO_N + 3) step(32'h0000_0000, 2'b00, 4'b0111, 4'h0);
    chk("to_pulses", to_seen, TO_EN ? 32'd1 : 32'd0);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [3:0]  rdy, rsp;
      a   = $urandom;
      rdy = 4'($urandom) | 4'($urandom) | 4'($urandom);
      rsp = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step(a, 2'($urandom), rdy, rsp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
